// File: rtl/render_frame_ctrl.sv
// Per-frame sequencer: clear, draw, optional vsync alignment, then buffer swap.
// Optional feature macro: RENDER_VSYNC_WAIT_EN (tear-free swap on VGA_VS falling edge).
module render_frame_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic        run,
    input  logic        VGA_VS,
    output logic        clear_start,
    input  logic        clear_done,
    output logic        draw_start,
    input  logic        draw_done,
    output logic        buf_sel,
    output logic [15:0] frame_count,
    output logic        busy,
    output logic        timeout_err
);

    localparam int unsigned WD_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    // Terminal cycle is the one whose increment would bring the count to TIMEOUT_CYCLES-1.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 2);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        CLEAR_WAIT,
        DRAW,
        DRAW_WAIT,
        SWAP
`ifdef RENDER_VSYNC_WAIT_EN
        , VSYNC_WAIT
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [WD_W-1:0]   wd_cnt;
    logic              wd_term;
    logic              wd_fire;
    logic              vs_fall;

`ifdef RENDER_VSYNC_WAIT_EN
    logic vs_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_q <= 1'b1;
        end else begin
            vs_q <= VGA_VS;
        end
    end

    assign vs_fall = vs_q & ~VGA_VS;
`else
    logic unused_vs;
    assign unused_vs = VGA_VS;
    assign vs_fall   = 1'b0;
`endif

    assign wd_term = (wd_cnt == WD_LAST);

    always_comb begin
        state_d = state_q;
        wd_fire = 1'b0;
        case (state_q)
            IDLE: begin
                if (run && !timeout_err) state_d = CLEAR;
            end
            CLEAR: state_d = CLEAR_WAIT;
            CLEAR_WAIT: begin
                if (clear_done) begin
                    state_d = DRAW;
                end else if (wd_term) begin
                    state_d = IDLE;
                    wd_fire = 1'b1;
                end
            end
            DRAW: state_d = DRAW_WAIT;
            DRAW_WAIT: begin
                if (draw_done) begin
`ifdef RENDER_VSYNC_WAIT_EN
                    state_d = VSYNC_WAIT;
`else
                    state_d = SWAP;
`endif
                end else if (wd_term) begin
                    state_d = IDLE;
                    wd_fire = 1'b1;
                end
            end
`ifdef RENDER_VSYNC_WAIT_EN
            VSYNC_WAIT: begin
                if (vs_fall) state_d = SWAP;
            end
`endif
            SWAP: state_d = run ? CLEAR : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        clear_start = (state_q == CLEAR);
        draw_start  = (state_q == DRAW);
        busy        = (state_q != IDLE);
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= IDLE;
            wd_cnt      <= '0;
            timeout_err <= 1'b0;
            buf_sel     <= 1'b0;
            frame_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == CLEAR || state_q == DRAW) begin
                wd_cnt <= '0;
            end else if (state_q == CLEAR_WAIT || state_q == DRAW_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (wd_fire) timeout_err <= 1'b1;
            if (state_q == SWAP) begin
                buf_sel     <= ~buf_sel;
                frame_count <= frame_count + 16'd1;
            end
        end
    end

endmodule

// File: doc/render_frame_ctrl.md
# render_frame_ctrl

Frame-sequencing control unit for the renderer: in each frame it runs clear, then draw, then waits for vertical sync, then swaps the display and draw buffers. It sits directly upstream of the framebuffer clear engine and the line/triangle drawer. It drives their `clear_start`/`draw_start` pulses and consumes their `clear_done`/`draw_done` pulses. It also tells the VGA read path which buffer to display.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1_000_000: maximum cycles to wait for `clear_done`/`draw_done`. The watchdog counter width is `$clog2(TIMEOUT_CYCLES)`.

Ports:
- `Clk`  in  1  system clock (50 MHz, `CLOCK_50`); one clock; all logic on rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset (board `KEY[0]`).
- `run`  in  1  level; 1 = render frames continuously.
- `VGA_VS`  in  1  active-low vertical sync from the VGA controller; synchronous to `Clk`.
- `clear_start`  out  1  one-cycle pulse starting the framebuffer clear.
- `clear_done`  in  1  one-cycle pulse from the clear engine.
- `draw_start`  out  1  one-cycle pulse starting the drawer.
- `draw_done`  in  1  one-cycle pulse from the drawer.
- `buf_sel`  out  1  buffer currently displayed. The draw/clear target is `~buf_sel`.
- `frame_count`  out  16  number of completed swaps.
- `busy`  out  1  1 whenever the state is not IDLE.
- `timeout_err`  out  1  sticky watchdog error flag.

## Operation
- Reset value of every output is 0, and the state is IDLE.
- The FSM has seven states: IDLE, CLEAR, CLEAR_WAIT, DRAW, DRAW_WAIT, VSYNC_WAIT, SWAP.
- IDLE -> CLEAR when `run`=1; otherwise the FSM stays in IDLE.
- CLEAR:
  - asserts `clear_start` for exactly 1 cycle;
  - -> CLEAR_WAIT.
- CLEAR_WAIT:
  - -> DRAW on `clear_done`=1;
  - `clear_done` in any other state is ignored.
- DRAW:
  - asserts `draw_start` for exactly 1 cycle;
  - -> DRAW_WAIT.
- DRAW_WAIT:
  - -> VSYNC_WAIT on `draw_done`=1;
  - `draw_done` in any other state is ignored.
- VSYNC_WAIT:
  - -> SWAP on a vsync falling edge: `vs_q`=1 and `VGA_VS`=0, where `vs_q` is `VGA_VS` registered one cycle (reset value 1);
  - edges occurring before this state is entered are not remembered.
- SWAP:
  - `buf_sel` <= `~buf_sel`;
  - `frame_count` <= `frame_count`+1, wrapping 0xFFFF -> 0x0000;
  - -> CLEAR if `run`=1, else -> IDLE.
- Deasserting `run` mid-frame never aborts; the current frame completes through SWAP.
- Watchdog:
  - the counter clears on entry to CLEAR_WAIT and DRAW_WAIT and increments every cycle in those states;
  - if it reaches `TIMEOUT_CYCLES`-1 without the done pulse, then `timeout_err` <= 1, the FSM goes to IDLE, and there is no swap and no count increment;
  - `timeout_err` clears only on reset;
  - while `timeout_err`=1, IDLE does not leave even with `run`=1.
- If the done pulse and the watchdog terminal count occur in the same cycle, done wins.
- Asserting `Reset_n` low in any state immediately returns all registers to their reset values, with no pulse glitch.

## Timing
- Run-to-start latency: `run` sampled 1 in IDLE at edge N gives `clear_start`=1 during cycle N+1.
- `clear_done` at edge M gives `draw_start`=1 during cycle M+1.
- `draw_done` at edge K gives VSYNC_WAIT from K+1. The earliest accepted vsync edge is sampled at K+1.
- A vsync edge sampled at edge V updates `buf_sel`/`frame_count` at edge V+1 (visible in cycle V+2). With `run`=1, `clear_start` follows one cycle after the swap.
- Minimum frame with zero-latency done and immediate vsync is 6 cycles.
- `busy` is registered-state decoded: 1 from the cycle after leaving IDLE until the cycle IDLE is re-entered.

## Configuration
- Macro `RENDER_VSYNC_WAIT_EN`.
- Defined: behaviour as above; swaps are aligned to the vsync falling edge (tear-free).
- Undefined:
  - the VSYNC_WAIT state and `vs_q` are not compiled;
  - DRAW_WAIT goes directly to SWAP on `draw_done`;
  - `VGA_VS` is unused;
  - minimum frame is 5 cycles.

## Test plan
- Reset: hold `Reset_n`=0 for 12 cycles, then release with `run`=0 -> all outputs 0, `busy`=0 for 100 cycles.
- Single frame: `run`=1 for one cycle; `clear_done` 20 cycles after `clear_start`; `draw_done` 50 cycles after `draw_start`; `VGA_VS` falls 10 cycles later -> exactly one `clear_start` and one `draw_start` pulse, `buf_sel`=1, `frame_count`=1, return to IDLE.
- Stale vsync: `VGA_VS` falls during DRAW_WAIT -> no swap; swap occurs only after the next falling edge.
- Continuous: `run`=1, loopback done pulses after 3 cycles, vsync every 200 cycles, 5 frames -> `frame_count`=5, `buf_sel`=1, one swap per vsync.
- Watchdog with `TIMEOUT_CYCLES`=64: no `clear_done` -> `timeout_err`=1 after 63 cycles in CLEAR_WAIT, FSM in IDLE, `frame_count` unchanged, no restart with `run`=1; reset clears the flag.
- Wrap: force `frame_count`=0xFFFF, then complete one frame -> `frame_count`=0x0000. Repeat with `RENDER_VSYNC_WAIT_EN` undefined -> swap one cycle after `draw_done`.
